// File: rtl/vga_pix_fifo.sv
// Pixel FIFO between a frame source and the VGA timing stage, with SOF hunt and sticky underflow.
// Optional underflow counter output uf_count enabled by macro VGA_PIX_FIFO_UFCNT_EN.
module vga_pix_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_pix,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [2:0]    s_data,
  input  logic          s_sof,
  output logic          s_ready,
  input  logic          de,
  input  logic          fs,
  output logic          vga_r,
  output logic          vga_g,
  output logic          vga_b,
  output logic [AW:0]   level,
  output logic          underflow
`ifdef VGA_PIX_FIFO_UFCNT_EN
  ,
  output logic [15:0]   uf_count
`endif
);

  typedef enum logic {HUNT, RUN} state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [2:0]      pix_q, pix_d;
  logic            uf_q, uf_d;
  logic [2:0]      mem_q [DEPTH];
  logic            push, wr_en, pop, uf_hit;

  assign s_ready = rst_n && (level_q != FULL);

  always_comb begin
    push    = s_valid && s_ready;
    wr_en   = 1'b0;
    pop     = 1'b0;
    uf_hit  = 1'b0;
    state_d = state_q;
    if (fs) begin
      // Frame start flushes; a same-cycle SOF word survives as the sole entry.
      wr_en   = push && s_sof;
      state_d = wr_en ? RUN : HUNT;
    end else if (state_q == HUNT) begin
      wr_en = push && s_sof;
      if (wr_en) state_d = RUN;
    end else begin
      wr_en  = push;
      pop    = de && (level_q != '0);
      uf_hit = de && (level_q == '0);
    end
    rd_ptr_d = fs ? wr_ptr_q : rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    level_d  = fs ? (AW+1)'(wr_en)
                  : level_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    pix_d    = pop ? mem_q[rd_ptr_q] : 3'b000;
    uf_d     = uf_q | uf_hit;
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pix_q    <= '0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pix_q    <= pix_d;
      uf_q     <= uf_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (wr_en) mem_q[wr_ptr_q] <= s_data;
  end

`ifdef VGA_PIX_FIFO_UFCNT_EN
  logic [15:0] ufc_q;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      ufc_q <= '0;
    end else if (uf_hit && (ufc_q != 16'hFFFF)) begin
      ufc_q <= ufc_q + 16'd1;
    end
  end

  assign uf_count = ufc_q;
`endif

  assign vga_r     = pix_q[2];
  assign vga_g     = pix_q[1];
  assign vga_b     = pix_q[0];
  assign level     = level_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_vga_pix_fifo.sv
// Scoreboard bench for vga_pix_fifo: queue-based frame model, directed scenarios then random traffic.
// Build with VGA_PIX_FIFO_UFCNT_EN defined to also check uf_count.
module tb_vga_pix_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk_pix = 1'b0;
  logic          rst_n   = 1'b0;
  logic          s_valid = 1'b0;
  logic [2:0]    s_data  = 3'b000;
  logic          s_sof   = 1'b0;
  logic          s_ready;
  logic          de      = 1'b0;
  logic          fs      = 1'b0;
  logic          vga_r, vga_g, vga_b;
  logic [AW:0]   level;
  logic          underflow;
`ifdef VGA_PIX_FIFO_UFCNT_EN
  logic [15:0]   uf_count;
`endif

  vga_pix_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .s_ready   (s_ready),
    .de        (de),
    .fs        (fs),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .level     (level),
    .underflow (underflow)
`ifdef VGA_PIX_FIFO_UFCNT_EN
    ,
    .uf_count  (uf_count)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic [2:0] vga;
    int         lvl;
    bit         uf;
    int         cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] mq[$];
  bit         m_run = 1'b0;
  bit         m_uf  = 1'b0;
  int         m_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(string name, int act, int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: frame semantics expressed on a plain queue.
  always @(posedge clk_pix) begin
    exp_t e;
    bit   acc;
    e.vga = 3'b000;
    if (!rst_n) begin
      mq.delete();
      m_run = 1'b0;
      m_uf  = 1'b0;
      m_cnt = 0;
    end else begin
      acc = s_valid && (mq.size() != DEPTH);
      if (fs) begin
        mq.delete();
        m_run = acc && s_sof;
        if (m_run) mq.push_back(s_data);
      end else if (!m_run) begin
        if (acc && s_sof) begin
          mq.push_back(s_data);
          m_run = 1'b1;
        end
      end else begin
        if (de) begin
          if (mq.size() > 0) begin
            e.vga = mq.pop_front();
          end else begin
            m_uf = 1'b1;
            if (m_cnt < 65535) m_cnt++;
          end
        end
        if (acc) mq.push_back(s_data);
      end
    end
    e.lvl = mq.size();
    e.uf  = m_uf;
    e.cnt = m_cnt;
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a registered pixel, level and flag.
  always @(negedge clk_pix) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("vga", int'({vga_r, vga_g, vga_b}), int'(e.vga));
      check("level", int'(level), e.lvl);
      check("underflow", int'(underflow), int'(e.uf));
`ifdef VGA_PIX_FIFO_UFCNT_EN
      check("uf_count", int'(uf_count), e.cnt);
`endif
    end
  end

  task automatic drive(bit r, bit v, logic [2:0] d, bit sof, bit den, bit f);
    @(negedge clk_pix);
    rst_n   = r;
    s_valid = v;
    s_data  = d;
    s_sof   = sof;
    de      = den;
    fs      = f;
    #1;
    check("s_ready", int'(s_ready), int'(r && (mq.size() != DEPTH)));
  endtask

  initial begin
    int de_pct;
    repeat (3) drive(0, 1, 3'b111, 1, 1, 0);
    // Hunt discards non-SOF words
    repeat (3) drive(1, 1, 3'b011, 0, 0, 0);
    // SOF then one more, read both
    drive(1, 1, 3'b101, 1, 0, 0);
    drive(1, 1, 3'b010, 0, 0, 0);
    drive(1, 0, 3'b000, 0, 1, 0);
    drive(1, 0, 3'b000, 0, 1, 0);
    drive(1, 0, 3'b000, 0, 0, 0);
    // Fill to full, attempt overflow, drain one
    for (int i = 0; i < 17; i++) drive(1, 1, 3'(i), 0, 0, 0);
    drive(1, 0, 3'b000, 0, 1, 0);
    drive(1, 0, 3'b000, 0, 0, 0);
    // Underflow on empty RUN, survives fs
    drive(0, 0, 3'b000, 0, 0, 0);
    drive(1, 1, 3'b110, 1, 0, 0);
    drive(1, 0, 3'b000, 0, 1, 0);
    repeat (3) drive(1, 0, 3'b000, 0, 1, 0);
    drive(1, 0, 3'b000, 0, 0, 1);
    drive(1, 0, 3'b000, 0, 0, 0);
    // fs with simultaneous SOF keeps sole entry
    drive(1, 1, 3'b001, 1, 0, 1);
    for (int i = 0; i < 7; i++) drive(1, 1, 3'(i), 0, 0, 0);
    drive(1, 1, 3'b111, 1, 1, 1);
    drive(1, 0, 3'b000, 0, 1, 0);
    drive(1, 0, 3'b000, 0, 0, 0);
    // Mid-frame reset
    drive(1, 1, 3'b100, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 3'(i + 3), 0, 0, 0);
    drive(0, 0, 3'b000, 0, 0, 0);
    drive(1, 0, 3'b000, 0, 1, 0);
    // Random traffic alternating fill-heavy and drain-heavy phases
    for (int p = 0; p < 12; p++) begin
      de_pct = (p % 3 == 0) ? 15 : ((p % 3 == 1) ? 60 : 90);
      for (int i = 0; i < 250; i++) begin
        drive(($urandom_range(0, 999) >= 3),
              ($urandom_range(0, 99) < 70),
              3'($urandom),
              ($urandom_range(0, 99) < 8),
              ($urandom_range(0, 99) < de_pct),
              ($urandom_range(0, 99) < 2));
      end
    end
    drive(1, 0, 3'b000, 0, 0, 0);
    @(negedge clk_pix);
    @(negedge clk_pix);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
